order_matcher: RTL and testbench

- Downstream consumer of the order generator: samples one buy price and one sell price on each rising edge of the generator's slow_clk.
- Rests each order in a small bid book and a small ask book.
- Scans both books for best bid (max) and best ask (min), and executes a trade whenever best bid >= best ask.
- Outputs feed the VGA analytics / display stage: trade strobe, trade price, book depths, best prices and counters.

---
 rtl/order_pkg.sv | 8 +
 rtl/order_matcher_book_side.sv | 87 ++++++++
 rtl/order_matcher.sv | 121 ++++++++++++
 tb/tb_order_matcher.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared types and constants for the order matcher and its book sides.
package order_pkg;
  localparam int unsigned PRICE_W_DEFAULT = 8;
  localparam logic [PRICE_W_DEFAULT-1:0] EMPTY_BID = '0;
  localparam logic [PRICE_W_DEFAULT-1:0] EMPTY_ASK = '1;

  typedef enum logic [1:0] {IDLE, INSERT, SCAN, MATCH} state_t;
endpackage

// File: rtl/order_matcher_book_side.sv
// One side of the book: resting slots, lowest-free insert, sequential best-price scan.
module book_side
  import order_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PRICE_W = PRICE_W_DEFAULT,
  parameter bit          IS_BID  = 1'b1,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned DW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_insert,
  input  logic [PRICE_W-1:0] i_price,
  output logic               o_full,
  input  logic               i_scan_clr,
  input  logic               i_scan_en,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_take,
  output logic               o_found,
  output logic [PRICE_W-1:0] o_price,
  output logic [DW-1:0]      o_depth
);
  localparam logic [PRICE_W-1:0] EMPTY = IS_BID ? '0 : '1;

  logic [PRICE_W-1:0] r_slot [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic               r_acc_found;
  logic [PRICE_W-1:0] r_acc_price;
  logic [IDX_W-1:0]   r_acc_idx;
  logic [DW-1:0]      r_depth;

  logic [IDX_W-1:0]   w_free_idx;
  logic               w_full;
  logic [DW-1:0]      w_pop;
  logic               w_better;

  always_comb begin
    w_free_idx = '0;
    w_full     = 1'b1;
    w_pop      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && w_full) begin
        w_free_idx = IDX_W'(i);
        w_full     = 1'b0;
      end
      w_pop = w_pop + DW'(r_valid[i]);
    end
  end

  // Strict compare keeps the earlier (lower-index) slot on equal prices.
  always_comb begin
    w_better = IS_BID ? (r_slot[i_idx] > r_acc_price) : (r_slot[i_idx] < r_acc_price);
  end

  always_ff @(posedge clk) begin
    if (i_insert && !w_full) r_slot[w_free_idx] <= i_price;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_acc_found <= 1'b0;
      r_acc_price <= EMPTY;
      r_acc_idx   <= '0;
      r_depth     <= '0;
    end else begin
      r_depth <= w_pop;
      if (i_insert && !w_full) r_valid[w_free_idx] <= 1'b1;
      if (i_take) r_valid[r_acc_idx] <= 1'b0;
      if (i_scan_clr) begin
        r_acc_found <= 1'b0;
        r_acc_price <= EMPTY;
        r_acc_idx   <= '0;
      end else if (i_scan_en && r_valid[i_idx] && (!r_acc_found || w_better)) begin
        r_acc_found <= 1'b1;
        r_acc_price <= r_slot[i_idx];
        r_acc_idx   <= i_idx;
      end
    end
  end

  assign o_full  = w_full;
  assign o_found = r_acc_found;
  assign o_price = r_acc_price;
  assign o_depth = r_depth;
endmodule

// File: rtl/order_matcher.sv
// Order matcher top: tick detection, insert/scan/match sequencing, trade and drop counters.
module order_matcher
  import order_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PRICE_W = PRICE_W_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       slow_clk,
  input  logic [PRICE_W-1:0]         buy_price,
  input  logic [PRICE_W-1:0]         sell_price,
  output logic                       trade_valid,
  output logic [PRICE_W-1:0]         trade_price,
  output logic [CNT_W-1:0]           trade_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic [$clog2(DEPTH+1)-1:0] bid_depth,
  output logic [$clog2(DEPTH+1)-1:0] ask_depth,
  output logic [PRICE_W-1:0]         best_bid,
  output logic [PRICE_W-1:0]         best_ask,
  output logic                       busy
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t             r_state;
  logic               r_tick_prev;
  logic [PRICE_W-1:0] r_buy, r_sell;
  logic [IDX_W-1:0]   r_idx;
  logic               r_trade_valid;
  logic [PRICE_W-1:0] r_trade_price, r_best_bid, r_best_ask;
  logic [CNT_W-1:0]   r_trade_count, r_drop_count;

  logic               w_tick, w_insert, w_scan_clr, w_scan_en, w_take, w_cross;
  logic               w_bid_full, w_ask_full, w_bid_found, w_ask_found;
  logic [PRICE_W-1:0] w_bid_px, w_ask_px;
  logic [CNT_W-1:0]   w_drop_inc;

  assign w_tick     = slow_clk & ~r_tick_prev;
  assign w_cross    = w_bid_found & w_ask_found & (w_bid_px >= w_ask_px);
  assign w_insert   = (r_state == INSERT);
  assign w_scan_en  = (r_state == SCAN);
  assign w_take     = (r_state == MATCH) & w_cross;
  assign w_scan_clr = w_insert | w_take;

  always_comb begin
    w_drop_inc = '0;
    if (w_insert) w_drop_inc = CNT_W'(w_bid_full) + CNT_W'(w_ask_full);
    if (r_state != IDLE && w_tick) w_drop_inc = w_drop_inc + CNT_W'(2);
  end

  book_side #(.DEPTH(DEPTH), .PRICE_W(PRICE_W), .IS_BID(1'b1)) u_bid (
    .clk(clk), .reset(reset), .i_insert(w_insert), .i_price(r_buy), .o_full(w_bid_full),
    .i_scan_clr(w_scan_clr), .i_scan_en(w_scan_en), .i_idx(r_idx), .i_take(w_take),
    .o_found(w_bid_found), .o_price(w_bid_px), .o_depth(bid_depth)
  );

  book_side #(.DEPTH(DEPTH), .PRICE_W(PRICE_W), .IS_BID(1'b0)) u_ask (
    .clk(clk), .reset(reset), .i_insert(w_insert), .i_price(r_sell), .o_full(w_ask_full),
    .i_scan_clr(w_scan_clr), .i_scan_en(w_scan_en), .i_idx(r_idx), .i_take(w_take),
    .o_found(w_ask_found), .o_price(w_ask_px), .o_depth(ask_depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick_prev   <= 1'b0;
      r_buy         <= '0;
      r_sell        <= '0;
      r_idx         <= '0;
      r_trade_valid <= 1'b0;
      r_trade_price <= '0;
      r_trade_count <= '0;
      r_drop_count  <= '0;
      r_best_bid    <= '0;
      r_best_ask    <= '1;
    end else begin
      r_tick_prev   <= slow_clk;
      r_trade_valid <= 1'b0;
      r_drop_count  <= r_drop_count + w_drop_inc;
      case (r_state)
        IDLE: if (w_tick) begin
          r_buy   <= buy_price;
          r_sell  <= sell_price;
          r_state <= INSERT;
        end
        INSERT: begin
          r_idx   <= '0;
          r_state <= SCAN;
        end
        SCAN: begin
          if (r_idx == IDX_W'(DEPTH - 1)) r_state <= MATCH;
          else r_idx <= r_idx + IDX_W'(1);
        end
        MATCH: begin
          r_best_bid <= w_bid_found ? w_bid_px : '0;
          r_best_ask <= w_ask_found ? w_ask_px : '1;
          // A trade rescans the whole book since one tick can uncover further crosses.
          if (w_cross) begin
            r_trade_price <= w_ask_px;
            r_trade_valid <= 1'b1;
            r_trade_count <= r_trade_count + CNT_W'(1);
            r_idx         <= '0;
            r_state       <= SCAN;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trade_valid = r_trade_valid;
  assign trade_price = r_trade_price;
  assign trade_count = r_trade_count;
  assign drop_count  = r_drop_count;
  assign best_bid    = r_best_bid;
  assign best_ask    = r_best_ask;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_order_matcher.sv
// Directed and randomized checks of order_matcher against a transaction-level book model.
module tb_order_matcher;
  localparam int D  = 4;
  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk, reset, slow_clk;
  logic [PW-1:0] buy_price, sell_price;
  logic          trade_valid, busy;
  logic [PW-1:0] trade_price, best_bid, best_ask;
  logic [CW-1:0] trade_count, drop_count;
  logic [2:0]    bid_depth, ask_depth;

  order_matcher #(.DEPTH(D), .PRICE_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk),
    .buy_price(buy_price), .sell_price(sell_price),
    .trade_valid(trade_valid), .trade_price(trade_price),
    .trade_count(trade_count), .drop_count(drop_count),
    .bid_depth(bid_depth), .ask_depth(ask_depth),
    .best_bid(best_bid), .best_ask(best_ask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference book: prices per slot with occupancy flags.
  logic [PW-1:0] m_bpx [D];
  logic [PW-1:0] m_apx [D];
  bit            m_bv  [D];
  bit            m_av  [D];
  int            m_tc, m_dc;
  logic [PW-1:0] m_tp, m_bb, m_ba;
  int            m_q  [$];
  int            m_qb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_bv[i] = 0; m_av[i] = 0;
    end
    m_tc = 0; m_dc = 0; m_tp = '0; m_bb = '0; m_ba = '1;
  endtask

  task automatic model_tick(input logic [PW-1:0] b, input logic [PW-1:0] s);
    int fb, fa, bi, ai;
    m_q.delete(); m_qb.delete();
    fb = -1; fa = -1;
    for (int i = 0; i < D; i++) begin
      if (!m_bv[i] && fb < 0) fb = i;
      if (!m_av[i] && fa < 0) fa = i;
    end
    if (fb < 0) m_dc++; else begin m_bv[fb] = 1; m_bpx[fb] = b; end
    if (fa < 0) m_dc++; else begin m_av[fa] = 1; m_apx[fa] = s; end
    for (int n = 0; n <= 2 * D; n++) begin
      bi = -1; ai = -1;
      for (int i = 0; i < D; i++) begin
        if (m_bv[i] && (bi < 0 || m_bpx[i] > m_bpx[bi])) bi = i;
        if (m_av[i] && (ai < 0 || m_apx[i] < m_apx[ai])) ai = i;
      end
      m_bb = (bi >= 0) ? m_bpx[bi] : '0;
      m_ba = (ai >= 0) ? m_apx[ai] : '1;
      if (bi >= 0 && ai >= 0 && m_bpx[bi] >= m_apx[ai]) begin
        m_tp = m_apx[ai];
        m_q.push_back(int'(m_apx[ai]));
        m_qb.push_back(int'(m_bpx[bi]));
        m_tc++;
        m_bv[bi] = 0; m_av[ai] = 0;
      end else break;
    end
  endtask

  task automatic count_books(output int nb, output int na);
    nb = 0; na = 0;
    for (int i = 0; i < D; i++) begin
      nb += int'(m_bv[i]); na += int'(m_av[i]);
    end
  endtask

  task automatic check_state(input string tag);
    int nb, na;
    count_books(nb, na);
    chk({tag, ".trade_count"}, trade_count, 32'(m_tc % 65536));
    chk({tag, ".drop_count"},  drop_count,  32'(m_dc % 65536));
    chk({tag, ".bid_depth"},   bid_depth,   nb);
    chk({tag, ".ask_depth"},   ask_depth,   na);
    chk({tag, ".best_bid"},    best_bid,    m_bb);
    chk({tag, ".best_ask"},    best_ask,    m_ba);
    chk({tag, ".trade_price"}, trade_price, m_tp);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One order pair; bt > 0 raises slow_clk again bt clocks after the capture edge.
  task automatic do_tick(input string tag, input logic [PW-1:0] b, input logic [PW-1:0] s, input int bt);
    int n, tend, j;
    bit done, exp_tv;
    buy_price = b; sell_price = s; slow_clk = 1'b1;
    @(posedge clk); #1;
    slow_clk = 1'b0;
    model_tick(b, s);
    if (bt > 0) m_dc += 2;
    n = m_q.size();
    tend = D + 2 + n * (D + 1);
    j = 0; done = 0;
    for (int t = 1; t <= 300; t++) begin
      @(posedge clk); #1;
      exp_tv = (j < n) && (t == D + 2 + j * (D + 1));
      chk({tag, ".trade_valid"}, trade_valid, exp_tv);
      if (exp_tv) begin
        chk({tag, ".trade_px"},  trade_price, m_q[j]);
        chk({tag, ".cross_bid"}, best_bid,    m_qb[j]);
        chk({tag, ".cross_ask"}, best_ask,    m_q[j]);
        j++;
      end
      if (t == bt) slow_clk = 1'b1;
      if (t == bt + 1) slow_clk = 1'b0;
      if (!busy) begin
        chk({tag, ".idle_at"}, t, tend);
        done = 1;
        break;
      end
    end
    if (!done) begin
      tests++; fails++;
      $error("FAIL %s.timeout: busy still %0d expected 0", tag, busy);
    end
    slow_clk = 1'b0;
    @(posedge clk); #1;
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; slow_clk = 1'b0; buy_price = '0; sell_price = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("rst.busy", busy, 0);
    chk("rst.trade_valid", trade_valid, 0);
    check_state("rst");

    // Cross on arrival
    do_tick("arrive", 8'd60, 8'd58, 0);

    // Rest then cross
    apply_reset();
    do_tick("rest", 8'd50, 8'd80, 0);
    do_tick("cross", 8'd85, 8'd90, 0);

    // Cross then rescan finds nothing
    apply_reset();
    do_tick("ch1", 8'd70, 8'd90, 0);
    do_tick("ch2", 8'd72, 8'd95, 0);
    do_tick("ch3", 8'd60, 8'd65, 0);

    // Book full
    apply_reset();
    for (int i = 0; i < 5; i++) do_tick("full", PW'(50 + i), PW'(100 + i), 0);

    // Second rising edge while busy
    apply_reset();
    buy_price = 8'd40; sell_price = 8'd90;
    do_tick("busy", 8'd40, 8'd90, 2);

    // Reset during SCAN idx=2
    apply_reset();
    do_tick("pre", 8'd30, 8'd99, 0);
    buy_price = 8'd90; sell_price = 8'd20; slow_clk = 1'b1;
    @(posedge clk); #1;
    slow_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("midrst.busy", busy, 0);
    chk("midrst.trade_valid", trade_valid, 0);
    check_state("midrst");
    @(posedge clk); #1;
    chk("midrst.trade_valid2", trade_valid, 0);

    // Randomized order flow
    for (int k = 0; k < 60; k++) begin
      logic [PW-1:0] b, s;
      int bt;
      b  = PW'($urandom_range(40, 90));
      s  = PW'($urandom_range(40, 90));
      bt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D + 1)) : 0;
      do_tick("rand", b, s, bt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
